// File: rtl/spi_ram_wrapper_pkg.sv
// Shared definitions for the SPI-to-RAM bridge: FSM state encoding,
// frame opcodes and frame geometry.
package spi_ram_wrapper_pkg;

    // One frame = 2-bit opcode + 8-bit payload
    localparam int unsigned FRAME_W   = 10;
    localparam int unsigned PAYLOAD_W = 8;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

endpackage

// File: rtl/spi_ram_wrapper_ram.sv
// Single-port RAM with opcode-driven address/data registers.
// Ports:
//   clk, rst_n            clock, async active-low reset (contents not cleared)
//   i_din, i_rx_valid     received frame {opcode, payload} and its strobe
//   o_dout, o_tx_valid    read data and one-cycle valid pulse
module spi_ram
    import spi_ram_wrapper_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ADDR_SIZE+1:0] i_din,
    input  logic                 i_rx_valid,
    output logic [ADDR_SIZE-1:0] o_dout,
    output logic                 o_tx_valid
);

    logic [ADDR_SIZE-1:0] mem [MEM_DEPTH];

    logic [ADDR_SIZE-1:0] r_wr_addr;
    logic [ADDR_SIZE-1:0] r_rd_addr;
    logic [ADDR_SIZE-1:0] r_dout;
    logic                 r_tx_valid;

    logic [1:0]           w_op;
    logic [ADDR_SIZE-1:0] w_payload;

    assign w_op      = i_din[ADDR_SIZE+1:ADDR_SIZE];
    assign w_payload = i_din[ADDR_SIZE-1:0];

    // Address registers and read port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr  <= '0;
            r_rd_addr  <= '0;
            r_dout     <= '0;
            r_tx_valid <= 1'b0;
        end else begin
            r_tx_valid <= 1'b0;
            if (i_rx_valid) begin
                case (w_op)
                    OP_WR_ADDR: r_wr_addr <= w_payload;
                    OP_RD_ADDR: r_rd_addr <= w_payload;
                    OP_RD_DATA: begin
                        r_dout     <= mem[r_rd_addr];
                        r_tx_valid <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Storage array has no reset so contents survive rst_n
    always_ff @(posedge clk) begin
        if (i_rx_valid && (w_op == OP_WR_DATA)) begin
            mem[r_wr_addr] <= w_payload;
        end
    end

    assign o_dout     = r_dout;
    assign o_tx_valid = r_tx_valid;

endmodule

// File: rtl/spi_ram_wrapper_slave.sv
// SPI slave: frames MOSI bits into rx_data/rx_valid and serialises RAM
// read data onto MISO.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   i_mosi, i_ss_n        serial in, active-low select
//   o_miso                serial out (registered)
//   o_rx_data, o_rx_valid received frame, one-cycle valid pulse
//   i_tx_data, i_tx_valid byte to return, one-cycle valid pulse
module spi_slave
    import spi_ram_wrapper_pkg::*;
#(
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_mosi,
    input  logic                 i_ss_n,
    output logic                 o_miso,
    output logic [ADDR_SIZE+1:0] o_rx_data,
    output logic                 o_rx_valid,
    input  logic [ADDR_SIZE-1:0] i_tx_data,
    input  logic                 i_tx_valid
);

    localparam int unsigned RX_W  = ADDR_SIZE + 2;
    localparam int unsigned CNT_W = $clog2(RX_W);
    localparam int unsigned TXC_W = $clog2(ADDR_SIZE);
    // Counter value on the edge that samples frame bit 0
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(RX_W - 2);

    state_t                 r_state;
    state_t                 w_next_state;
    logic [CNT_W-1:0]       r_bit_cnt;
    logic [RX_W-2:0]        r_rx_shift;
    logic [ADDR_SIZE+1:0]   r_rx_data;
    logic                   r_rx_valid;
    logic                   r_rd_flag;
    logic [ADDR_SIZE-1:0]   r_tx_shift;
    logic [TXC_W-1:0]       r_tx_cnt;
    logic                   r_miso;

    logic                   w_in_frame;
    logic                   w_sample;
    logic                   w_frame_done;
    logic                   w_tx_load;
    logic                   w_tx_shift;
    logic                   w_rd_addr_done;
    logic                   w_rd_data_done;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; deasserted select always returns to IDLE
    always_comb begin
        w_next_state = r_state;
        if (i_ss_n) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE:      w_next_state = CHK_CMD;
                CHK_CMD: begin
                    if (!i_mosi)        w_next_state = WRITE;
                    else if (r_rd_flag) w_next_state = READ_DATA;
                    else                w_next_state = READ_ADD;
                end
                WRITE, READ_ADD: begin
                    if (r_bit_cnt == LAST_BIT) w_next_state = IDLE;
                end
                READ_DATA: w_next_state = READ_DATA;
                default:   w_next_state = IDLE;
            endcase
        end
    end

    // Control decode
    always_comb begin
        w_in_frame     = 1'b0;
        w_sample       = 1'b0;
        w_frame_done   = 1'b0;
        w_tx_load      = 1'b0;
        w_tx_shift     = 1'b0;
        w_rd_addr_done = 1'b0;
        w_rd_data_done = 1'b0;
        w_in_frame = (r_state == WRITE) || (r_state == READ_ADD) || (r_state == READ_DATA);
        if (!i_ss_n) begin
            w_sample       = (r_state == CHK_CMD) || (w_in_frame && (r_bit_cnt <= LAST_BIT));
            w_frame_done   = w_in_frame && (r_bit_cnt == LAST_BIT);
            w_rd_addr_done = w_frame_done && (r_state == READ_ADD);
            // Only a read-data frame turns RAM output into MISO traffic
            w_tx_load      = (r_state == READ_DATA) && i_tx_valid;
            w_tx_shift     = !w_tx_load && (r_tx_cnt != '0);
            w_rd_data_done = w_tx_shift && (r_tx_cnt == TXC_W'(1));
        end
    end

    // Receive path: bit counter, shift register, frame strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bit_cnt  <= '0;
            r_rx_shift <= '0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
        end else begin
            r_rx_valid <= 1'b0;
            if (i_ss_n || (r_state == IDLE) || (r_state == CHK_CMD)) begin
                r_bit_cnt <= '0;
            end else if (w_sample) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end
            if (w_sample) begin
                r_rx_shift <= {r_rx_shift[RX_W-3:0], i_mosi};
            end
            if (w_frame_done) begin
                r_rx_data  <= {r_rx_shift, i_mosi};
                r_rx_valid <= 1'b1;
            end
        end
    end

    // Read-address-received flag: armed by a read-address frame, consumed by a full readout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_flag <= 1'b0;
        end else if (w_rd_addr_done) begin
            r_rd_flag <= 1'b1;
        end else if (w_rd_data_done) begin
            r_rd_flag <= 1'b0;
        end
    end

    // Transmit path: MSB first, idles low
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_shift <= '0;
            r_tx_cnt   <= '0;
            r_miso     <= 1'b0;
        end else if (i_ss_n) begin
            r_tx_cnt <= '0;
            r_miso   <= 1'b0;
        end else if (w_tx_load) begin
            r_miso     <= i_tx_data[ADDR_SIZE-1];
            r_tx_shift <= {i_tx_data[ADDR_SIZE-2:0], 1'b0};
            r_tx_cnt   <= TXC_W'(ADDR_SIZE - 1);
        end else if (w_tx_shift) begin
            r_miso     <= r_tx_shift[ADDR_SIZE-1];
            r_tx_shift <= {r_tx_shift[ADDR_SIZE-2:0], 1'b0};
            r_tx_cnt   <= r_tx_cnt - TXC_W'(1);
        end else begin
            r_miso <= 1'b0;
        end
    end

    assign o_miso     = r_miso;
    assign o_rx_data  = r_rx_data;
    assign o_rx_valid = r_rx_valid;

endmodule

// File: rtl/spi_ram_wrapper.sv
// SPI-to-RAM bridge top: connects the serial slave to the RAM.
// Ports:
//   clk, rst_n   clock, async active-low reset
//   MOSI, SS_n   serial data in, active-low select
//   MISO         serial data out
module spi_ram_wrapper
    import spi_ram_wrapper_pkg::*;
#(
    parameter int unsigned MEM_DEPTH = 256,
    parameter int unsigned ADDR_SIZE = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic MOSI,
    input  logic SS_n,
    output logic MISO
);

    logic [ADDR_SIZE+1:0] w_rx_data;
    logic                 w_rx_valid;
    logic [ADDR_SIZE-1:0] w_tx_data;
    logic                 w_tx_valid;

    spi_slave #(
        .ADDR_SIZE (ADDR_SIZE)
    ) u_slave (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_mosi     (MOSI),
        .i_ss_n     (SS_n),
        .o_miso     (MISO),
        .o_rx_data  (w_rx_data),
        .o_rx_valid (w_rx_valid),
        .i_tx_data  (w_tx_data),
        .i_tx_valid (w_tx_valid)
    );

    spi_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) ram (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_din      (w_rx_data),
        .i_rx_valid (w_rx_valid),
        .o_dout     (w_tx_data),
        .o_tx_valid (w_tx_valid)
    );

endmodule

// File: tb/tb_spi_ram_wrapper.sv
// Scoreboard bench for spi_ram_wrapper: stimulus pushes expected frames and
// MISO bits computed by a frame-level model; monitors compare every cycle.
`timescale 1ns/1ps
module tb_spi_ram_wrapper;
    import spi_ram_wrapper_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic MOSI;
    logic SS_n;
    logic MISO;

    always #5 clk = ~clk;

    spi_ram_wrapper #(.MEM_DEPTH(256), .ADDR_SIZE(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .MOSI  (MOSI),
        .SS_n  (SS_n),
        .MISO  (MISO)
    );

    int checks = 0;
    int errors = 0;
    logic [31:0] cyc = 32'd0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // Frame-level reference model
    logic [7:0] m_mem [256];
    logic [7:0] m_wr_addr;
    logic [7:0] m_rd_addr;
    bit         m_flag;

    typedef struct packed {
        logic [31:0] cyc;
        logic [9:0]  data;
    } rx_exp_t;

    rx_exp_t q_rx [$];
    bit      exp_miso [logic [31:0]];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: MISO every cycle, received frames on each rx_valid
    always @(negedge clk) begin
        if (rst_n) begin
            rx_exp_t e;
            check("miso", 32'(MISO), exp_miso.exists(cyc) ? 32'(exp_miso[cyc]) : 32'd0);
            if (dut.w_rx_valid) begin
                check("rx_expected", 32'(q_rx.size() != 0), 32'd1);
                if (q_rx.size() != 0) begin
                    e = q_rx.pop_front();
                    check("rx_cycle", cyc, e.cyc);
                    check("rx_data", 32'(dut.w_rx_data), 32'(e.data));
                end
            end
        end
    end

    // Drive values sampled by the next rising edge
    task automatic drive(input bit ss, input bit mosi);
        @(negedge clk);
        SS_n = ss;
        MOSI = mosi;
    endtask

    // Full frame; for read-data frames keep SS_n low for `hold` edges after bit 0
    task automatic send_frame(input logic [1:0] op, input logic [7:0] pl, input int hold);
        logic [9:0]  fr;
        logic [31:0] a;
        logic [7:0]  data;
        bit          is_rd_data;
        fr = {op, pl};
        data = 8'h00;
        drive(1'b0, 1'($urandom_range(0, 1)));
        for (int i = 9; i >= 0; i--) drive(1'b0, fr[i]);
        a = cyc + 32'd1;
        q_rx.push_back('{cyc: a, data: fr});
        is_rd_data = 1'b0;
        if (op[1]) begin
            if (m_flag) is_rd_data = 1'b1;
            else        m_flag = 1'b1;
        end
        case (op)
            OP_WR_ADDR: m_wr_addr = pl;
            OP_WR_DATA: m_mem[m_wr_addr] = pl;
            OP_RD_ADDR: m_rd_addr = pl;
            default:    data = m_mem[m_rd_addr];
        endcase
        if (is_rd_data) begin
            if (op == OP_RD_DATA) begin
                for (int k = 0; k < 8; k++)
                    if (k + 2 <= hold) exp_miso[a + 32'(k + 2)] = data[7-k];
                if (hold >= 9) m_flag = 1'b0;
            end
            for (int i = 0; i < hold; i++) drive(1'b0, 1'($urandom_range(0, 1)));
        end
        drive(1'b1, 1'($urandom_range(0, 1)));
        repeat (2) @(negedge clk);
    endtask

    // Partial frame cut off after nbits data bits
    task automatic abort_frame(input logic [9:0] fr, input int nbits);
        drive(1'b0, 1'($urandom_range(0, 1)));
        for (int i = 0; i < nbits; i++) drive(1'b0, fr[9-i]);
        drive(1'b1, 1'($urandom_range(0, 1)));
        repeat (2) @(negedge clk);
    endtask

    task automatic check_mem(input string tag);
        for (int i = 0; i < 256; i++)
            check($sformatf("%s[%0h]", tag, i), 32'(dut.ram.mem[i]), 32'(m_mem[i]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        logic [7:0]  v;
        rst_n = 1'b0;
        SS_n  = 1'b1;
        MOSI  = 1'b0;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            dut.ram.mem[i] = v;
            m_mem[i] = v;
        end
        m_flag = 1'b0;
        m_wr_addr = 8'h00;
        m_rd_addr = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_state", 32'(dut.u_slave.r_state), 32'(IDLE));
        check("rst_cnt", 32'(dut.u_slave.r_bit_cnt), 32'd0);
        check("rst_rx_valid", 32'(dut.w_rx_valid), 32'd0);
        check("rst_tx_valid", 32'(dut.w_tx_valid), 32'd0);
        check("rst_flag", 32'(dut.u_slave.r_rd_flag), 32'd0);
        check("rst_wr_addr", 32'(dut.ram.r_wr_addr), 32'd0);
        check("rst_rd_addr", 32'(dut.ram.r_rd_addr), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: write address
        send_frame(OP_WR_ADDR, 8'hAC, 0);
        check("t1_wr_addr", 32'(dut.ram.r_wr_addr), 32'(m_wr_addr));
        // 2: write data
        send_frame(OP_WR_DATA, 8'h5A, 0);
        check_mem("t2_mem");
        // 3: read address with forced content
        dut.ram.mem[8'hAC] = 8'h7B;
        m_mem[8'hAC] = 8'h7B;
        send_frame(OP_RD_ADDR, 8'hAC, 0);
        check("t3_flag", 32'(dut.u_slave.r_rd_flag), 32'(m_flag));
        check("t3_rd_addr", 32'(dut.ram.r_rd_addr), 32'(m_rd_addr));
        // 4: full readout
        send_frame(OP_RD_DATA, 8'h00, 10);
        check("t4_flag", 32'(dut.u_slave.r_rd_flag), 32'(m_flag));
        // 5: aborted write-data frame, then a clean frame
        abort_frame({OP_WR_DATA, 8'h33}, 5);
        check_mem("t5_mem");
        send_frame(OP_WR_ADDR, 8'h12, 0);
        check("t5_wr_addr", 32'(dut.ram.r_wr_addr), 32'(m_wr_addr));

        // 6: reset in the middle of a readout
        send_frame(OP_RD_ADDR, 8'h40, 0);
        drive(1'b0, 1'b1);
        v = 8'h00;
        for (int i = 9; i >= 0; i--) drive(1'b0, (i >= 8) ? 1'b1 : v[i]);
        a = cyc + 32'd1;
        q_rx.push_back('{cyc: a, data: {OP_RD_DATA, 8'h00}});
        for (int k = 0; k < 8; k++) exp_miso[a + 32'(k + 2)] = m_mem[m_rd_addr][7-k];
        repeat (4) drive(1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("t6_miso_async", 32'(MISO), 32'd0);
        check("t6_state", 32'(dut.u_slave.r_state), 32'(IDLE));
        for (int k = 0; k < 12; k++)
            if (exp_miso.exists(cyc + 32'(k))) exp_miso.delete(cyc + 32'(k));
        m_flag = 1'b0;
        m_wr_addr = 8'h00;
        m_rd_addr = 8'h00;
        SS_n = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_mem("t6_mem");
        send_frame(OP_RD_DATA, 8'h00, 10);
        check("t6_flag_set", 32'(dut.u_slave.r_rd_flag), 32'(m_flag));
        send_frame(OP_RD_DATA, 8'h00, 10);
        check("t6_flag_clr", 32'(dut.u_slave.r_rd_flag), 32'(m_flag));

        // Randomized traffic
        for (int n = 0; n < 80; n++) begin
            case ($urandom_range(0, 4))
                0: send_frame(OP_WR_ADDR, 8'($urandom), 0);
                1: send_frame(OP_WR_DATA, 8'($urandom), 0);
                2: begin
                    if (!m_flag) send_frame(OP_RD_ADDR, 8'($urandom), 0);
                    else         send_frame(OP_RD_DATA, 8'($urandom), int'($urandom_range(0, 12)));
                end
                3: abort_frame(10'($urandom), int'($urandom_range(1, 9)));
                default: repeat ($urandom_range(1, 3)) drive(1'b1, 1'($urandom_range(0, 1)));
            endcase
        end
        check("rand_flag", 32'(dut.u_slave.r_rd_flag), 32'(m_flag));
        check_mem("final_mem");
        check("rx_pending", 32'(q_rx.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
